// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-ported SRAM.
// Grants are combinational; read data returns one cycle after the grant, and writes get no response.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       i_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    sram_en      = 1'b0;
    sram_wen     = 4'd0;
    sram_addr    = 32'd0;
    sram_wdata   = 32'd0;

    // Data normally wins a contested cycle; fetch forced through once starved.
    i_win = i_req && (!d_req || (starve_cnt_q == LIMIT));
    if (!rst) begin
      i_gnt = i_win;
      d_gnt = d_req && !i_win;
    end

    if (i_gnt) begin
      sram_en   = 1'b1;
      sram_addr = i_addr;
      state_d   = RESP_I;
    end else if (d_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = d_wen;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
      state_d    = (d_wen == 4'd0) ? RESP_D : IDLE;
    end

    if (i_gnt || !i_req) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  assign i_rvalid = (state_q == RESP_I);
  assign d_rvalid = (state_q == RESP_D);
  assign i_rdata  = i_rvalid ? sram_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? sram_rdata : 32'd0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the maximum number of consecutive contested data grants before instruction fetch is forced through (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch read request.
REQ-005 i_addr  input  32  instruction byte address.
REQ-006 i_gnt  output  1  instruction request accepted this cycle.
REQ-007 i_rvalid  output  1  instruction read data valid.
REQ-008 i_rdata  output  32  instruction read data.
REQ-009 d_req  input  1  data-port request.
REQ-010 d_wen  input  4  byte write enables; 4'b0000 means read.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_gnt  output  1  data request accepted this cycle.
REQ-014 d_rvalid  output  1  data read data valid (reads only).
REQ-015 d_rdata  output  32  data read data.
REQ-016 sram_en  output  1  shared SRAM enable.
REQ-017 sram_wen  output  4  shared SRAM byte write enables.
REQ-018 sram_addr  output  32  shared SRAM address.
REQ-019 sram_wdata  output  32  shared SRAM write data.
REQ-020 sram_rdata  input  32  shared SRAM read data, valid one cycle after a read-enable cycle.

Function
REQ-021 At most one of i_gnt/d_gnt SHALL be high in any cycle; grants are combinational from requests, response-FSM state and starvation counter.
REQ-022 Only one requester active: that requester SHALL be granted in the same cycle.
REQ-023 Both requesting: d_gnt SHALL win unless starve_cnt == STARVE_LIMIT, in which case i_gnt wins.
REQ-024 starve_cnt (4 bits) SHALL increment on each cycle with d_gnt && i_req, saturating at STARVE_LIMIT; clear on any i_gnt or any cycle with i_req low.
REQ-025 Grant cycle: sram_en=1, sram_addr/sram_wdata/sram_wen driven from the granted port; instruction grants drive sram_wen=0, sram_wdata=0.
REQ-026 No grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
REQ-027 Response FSM states: IDLE, RESP_I, RESP_D; next state RESP_I after i_gnt, RESP_D after d_gnt with d_wen==0, IDLE otherwise (including d_gnt write).
REQ-028 i_rvalid = (state==RESP_I), d_rvalid = (state==RESP_D); read latency exactly one cycle from grant.
REQ-029 i_rdata/d_rdata SHALL equal sram_rdata while the matching rvalid is high, 32'b0 otherwise.
REQ-030 A new grant SHALL be allowed in a RESP_* cycle (back-to-back accesses, one per cycle, no bubble).
REQ-031 Writes complete in the grant cycle; no write response is generated.
REQ-032 Requesters hold req and payload stable until granted; arbiter stores no request payload.
REQ-033 Req dropped before grant: no SRAM access, no response, starve_cnt per REQ-024.

Reset
REQ-034 rst high SHALL immediately force state=IDLE, starve_cnt=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0.
REQ-035 During rst, i_gnt=d_gnt=0 and all sram_* outputs 0 regardless of requests.
REQ-036 A response outstanding when rst asserts SHALL be discarded; no rvalid after rst deasserts without a new grant.

Verification
REQ-037 i_req=1, i_addr=0xBFC00000, d_req=0 -> i_gnt=1, sram_en=1, sram_addr=0xBFC00000, sram_wen=0; next cycle i_rvalid=1, i_rdata=sram_rdata.
REQ-038 d_req=1, d_wen=4'b0011, d_addr=0x100, d_wdata=0x12345678 -> d_gnt=1, sram_wen=4'b0011, sram_wdata=0x12345678; next cycle d_rvalid=0.
REQ-039 Both requesting continuously (d reads), STARVE_LIMIT=4 -> d_gnt cycles 1-4, i_gnt cycle 5, d_gnt cycles 6-9, i_gnt cycle 10.
REQ-040 Alternating single grants i,d,i every cycle (d reads) -> rvalid pattern i,d,i one cycle later, no idle cycles.
REQ-041 rst asserted the cycle after a d read grant -> d_rvalid stays 0, all outputs 0 during rst, no response after release.
REQ-042 Neither requesting -> all grants, rvalids and sram_* outputs 0; starve_cnt 0.
